kbd_scan_ctrl: RTL and testbench

//  Sequences raw PS/2 scan-code bytes from the keyboard receiver into key events.

---
 rtl/kbd_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_kbd_scan_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl
//   Turns raw PS/2 scan-code bytes into key events. Handles the E0 (extended)
//   and F0 (break) prefixes, drops typematic repeats, swallows the 8-byte Pause
//   sequence and the E0 12 / E0 59 fake-shift codes, and counts new presses.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   rx_data    in   [7:0] scan-code byte from the PS/2 receiver
//   rx_valid   in   rx_data valid; held by the receiver until consumed
//   rx_ready   out  high whenever not in reset
//   key        out  [7:0] last make code, prefixes stripped
//   ext        out  key carried the E0 prefix
//   is_press   out  key currently held down
//   count      out  [7:0] accepted new presses, mod 256
//   key_evt    out  1-cycle pulse per accepted new press
//   proto_err  out  1-cycle pulse on a prefix error or timeout
//
// Handshake: a byte is transferred on a rising edge where rx_valid && rx_ready;
// the sender keeps rx_data stable while rx_valid is high and not yet consumed.
module kbd_scan_ctrl #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] key,
  output logic       ext,
  output logic       is_press,
  output logic [7:0] count,
  output logic       key_evt,
  output logic       proto_err
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP
  } state_t;

  state_t        state, state_d;
  logic [2:0]    skip_cnt, skip_d;
  logic [TW-1:0] timer, timer_d;
  logic [7:0]    key_d, count_d;
  logic          ext_d, press_d, evt_d, err_d;
  logic          make_req, brk_req, ext_sel, same_key;
  logic          consume;

  assign rx_ready = !rst;
  assign consume  = rx_valid && rx_ready;
  // The incoming byte names the key that is already held (repeat / matching release).
  assign same_key = is_press && (key == rx_data) && (ext == ext_sel);

  always_comb begin
    state_d  = state;
    skip_d   = skip_cnt;
    timer_d  = timer;
    key_d    = key;
    ext_d    = ext;
    press_d  = is_press;
    count_d  = count;
    evt_d    = 1'b0;
    err_d    = 1'b0;
    make_req = 1'b0;
    brk_req  = 1'b0;
    ext_sel  = 1'b0;

    if (consume) begin
      // A byte always beats a timeout that would fire in the same cycle.
      timer_d = '0;
      case (state)
        S_IDLE: begin
          case (rx_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin state_d = S_SKIP; skip_d = 3'd7; end
            8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF: ;
            default: make_req = 1'b1;
          endcase
        end
        S_EXT: begin
          ext_sel = 1'b1;
          state_d = S_IDLE;
          case (rx_data)
            8'hF0: state_d = S_EXTBRK;
            8'h12, 8'h59: ;
            8'hE0, 8'hE1: err_d = 1'b1;
            default: make_req = 1'b1;
          endcase
        end
        S_BRK: begin
          state_d = S_IDLE;
          case (rx_data)
            8'hE0, 8'hF0, 8'hE1: err_d = 1'b1;
            default: brk_req = 1'b1;
          endcase
        end
        S_EXTBRK: begin
          ext_sel = 1'b1;
          state_d = S_IDLE;
          case (rx_data)
            8'hE0, 8'hF0, 8'hE1: err_d = 1'b1;
            8'h12, 8'h59: ;
            default: brk_req = 1'b1;
          endcase
        end
        S_SKIP: begin
          // skip_cnt==1 marks the last of the 7 bytes following E1.
          if (skip_cnt == 3'd1) state_d = S_IDLE;
          else skip_d = skip_cnt - 3'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      if (timer == T_LAST) begin
        state_d = S_IDLE;
        timer_d = '0;
        err_d   = 1'b1;
      end else begin
        timer_d = timer + TW'(1);
      end
    end

    if (make_req && !same_key) begin
      key_d   = rx_data;
      ext_d   = ext_sel;
      press_d = 1'b1;
      count_d = count + 8'd1;
      evt_d   = 1'b1;
    end
    // A release of some other key (rollover) is ignored.
    if (brk_req && same_key) press_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      skip_cnt  <= 3'd0;
      timer     <= '0;
      key       <= 8'h00;
      ext       <= 1'b0;
      is_press  <= 1'b0;
      count     <= 8'h00;
      key_evt   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_d;
      skip_cnt  <= skip_d;
      timer     <= timer_d;
      key       <= key_d;
      ext       <= ext_d;
      is_press  <= press_d;
      count     <= count_d;
      key_evt   <= evt_d;
      proto_err <= err_d;
    end
  end

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl with a short timeout so the timeout paths
// are reachable in a few cycles.
module tb_kbd_scan_ctrl;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] key;
  logic       ext;
  logic       is_press;
  logic [7:0] count;
  logic       key_evt;
  logic       proto_err;

  int n_checks = 0;
  int n_fail   = 0;
  int evt_total = 0;
  int err_total = 0;

  kbd_scan_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .key(key), .ext(ext), .is_press(is_press),
    .count(count), .key_evt(key_evt), .proto_err(proto_err)
  );

  // clock / pulse tally
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_evt) evt_total++;
    if (proto_err) err_total++;
    if (key_evt && proto_err) check("evt_err_excl", 1, 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: present one byte, it is consumed on the next rising edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int e0, r0, cyc;
  logic seen;
  logic [7:0] exp_cnt;

  initial begin
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h1C;
    repeat (3) @(negedge clk);
    check("rst_ready", rx_ready, 0);
    check("rst_count", count, 0);
    check("rst_key", key, 0);
    check("rst_ext", ext, 0);
    check("rst_press", is_press, 0);
    check("rst_evt", key_evt, 0);
    check("rst_err", proto_err, 0);
    rx_valid = 1'b0;
    rst = 1'b0;
    settle();
    check("ready_run", rx_ready, 1);
    check("no_consume_in_rst", count, 0);

    // single make, pulse width
    e0 = evt_total;
    send(8'h1C);
    @(negedge clk);
    check("make_evt_hi", key_evt, 1);
    @(negedge clk);
    check("make_evt_lo", key_evt, 0);
    check("make_key", key, 8'h1C);
    check("make_ext", ext, 0);
    check("make_press", is_press, 1);
    check("make_count", count, 1);
    settle();
    check("make_evt_n", evt_total - e0, 1);

    // typematic repeats then release
    e0 = evt_total;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    settle();
    check("rep_count", count, 1);
    check("rep_evt_n", evt_total - e0, 0);
    check("rep_press", is_press, 0);
    check("rep_key", key, 8'h1C);

    // extended make / break
    send(8'hE0); send(8'h75);
    settle();
    check("ext_key", key, 8'h75);
    check("ext_ext", ext, 1);
    check("ext_press", is_press, 1);
    check("ext_count", count, 2);
    send(8'hE0); send(8'hF0); send(8'h75);
    settle();
    check("ext_brk_press", is_press, 0);
    check("ext_brk_key", key, 8'h75);

    // fake shift ignored
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h75);
    settle();
    check("fs_key", key, 8'h75);
    check("fs_ext", ext, 1);
    check("fs_count", count, 3);

    // rollover: release of an older key is ignored
    send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C);
    settle();
    check("roll_key", key, 8'h32);
    check("roll_press", is_press, 1);
    check("roll_count", count, 5);
    send(8'hF0); send(8'h32);
    settle();
    check("roll_rel", is_press, 0);

    // discards in IDLE and EXTBRK
    e0 = evt_total; r0 = err_total;
    send(8'hAA); send(8'hFA); send(8'hE0); send(8'hF0); send(8'h12);
    settle();
    check("disc_evt", evt_total - e0, 0);
    check("disc_err", err_total - r0, 0);
    check("disc_count", count, 5);
    check("disc_key", key, 8'h32);

    // prefix error returns to IDLE
    r0 = err_total;
    send(8'hF0); send(8'hE0);
    settle();
    check("perr_n", err_total - r0, 1);
    send(8'h33);
    settle();
    check("perr_key", key, 8'h33);
    check("perr_ext", ext, 0);
    check("perr_count", count, 6);

    // timeout after F0: pulse exactly T cycles after the prefix
    r0 = err_total;
    send(8'hF0);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 4 * T) begin
      @(posedge clk); cyc++; #1; seen = proto_err;
    end
    check("to_latency", cyc, T);
    @(posedge clk); #1;
    check("to_pulse_lo", proto_err, 0);
    check("to_n", err_total - r0, 1);
    send(8'h1C);
    settle();
    check("to_next_make", count, 7);
    check("to_next_press", is_press, 1);

    // byte arriving on the timeout cycle wins
    r0 = err_total;
    send(8'hF0);
    repeat (T - 1) @(posedge clk);
    send(8'h1C);
    settle();
    check("win_err", err_total - r0, 0);
    check("win_press", is_press, 0);

    // Pause sequence swallowed
    e0 = evt_total; r0 = err_total;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    settle();
    check("pause_evt", evt_total - e0, 0);
    check("pause_err", err_total - r0, 0);
    check("pause_key", key, 8'h1C);
    check("pause_count", count, 7);
    check("pause_press", is_press, 0);
    send(8'h1C);
    settle();
    check("pause_next", count, 8);

    // 256 alternating makes wrap the counter
    e0 = evt_total;
    exp_cnt = 8'd8;
    for (int i = 0; i < 256; i++) begin
      send((i % 2 == 0) ? 8'h32 : 8'h1C);
      exp_cnt = exp_cnt + 8'd1;
      if (exp_cnt == 8'h00) begin
        @(negedge clk);
        check("wrap_zero", count, 0);
      end
    end
    settle();
    check("wrap_count", count, 8);
    check("wrap_evt_n", evt_total - e0, 256);
    check("wrap_key", key, 8'h1C);

    // reset mid-sequence drops the pending E0
    send(8'hE0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_key", key, 0);
    check("mid_rst_press", is_press, 0);
    send(8'h75);
    settle();
    check("mid_rst_ext", ext, 0);
    check("mid_rst_key2", key, 8'h75);
    check("mid_rst_count2", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
